// File: rtl/uart_tx_serializer_pkg.sv
// Shared definitions for the UART transmit serializer: state encoding,
// default word width and parity-type constants.
package uart_tx_serializer_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // A one-bit word still needs a one-bit counter register.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_serializer_parity.sv
// Parity generator for the latched transmit word: reduction XOR built as an
// explicit chain, inverted for odd parity.
module tx_parity_calc
  import uart_tx_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  parity_bit
);

  logic [DATA_WIDTH-1:0] xor_chain;

  assign xor_chain[0] = data[0];

  genvar gi;
  generate
    for (gi = 1; gi < DATA_WIDTH; gi++) begin : g_xor
      assign xor_chain[gi] = xor_chain[gi-1] ^ data[gi];
    end
  endgenerate

  assign parity_bit = xor_chain[DATA_WIDTH-1] ^ (par_typ == ODD);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART frame serializer: start bit, LSB-first data, optional parity, stop bit.
// TX_OUT and Busy are registered and computed from the next state.
module uart_tx_serializer
  import uart_tx_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int CNT_W = cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  tx_state_e             state_reg, state_next;
  logic [CNT_W-1:0]      bit_cnt_reg, bit_cnt_next;
  logic [DATA_WIDTH-1:0] data_reg, data_next;
  logic                  par_en_reg, par_en_next;
  logic                  par_typ_reg, par_typ_next;
  logic                  tx_out_reg, tx_out_next;
  logic                  busy_reg, busy_next;
  logic                  parity_bit;

  tx_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .data      (data_reg),
    .par_typ   (par_typ_reg),
    .parity_bit(parity_bit)
  );

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      data_reg    <= '0;
      par_en_reg  <= 1'b0;
      par_typ_reg <= 1'b0;
      tx_out_reg  <= 1'b1;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      data_reg    <= data_next;
      par_en_reg  <= par_en_next;
      par_typ_reg <= par_typ_next;
      tx_out_reg  <= tx_out_next;
      busy_reg    <= busy_next;
    end
  end

  // Outputs describe the line level of the state being entered.
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    data_next    = data_reg;
    par_en_next  = par_en_reg;
    par_typ_next = par_typ_reg;
    tx_out_next  = 1'b1;
    busy_next    = 1'b1;
    case (state_reg)
      IDLE: begin
        busy_next = 1'b0;
        if (Data_valid) begin
          state_next   = START;
          data_next    = P_DATA;
          par_en_next  = PAR_EN;
          par_typ_next = PAR_TYP;
          tx_out_next  = 1'b0;
          busy_next    = 1'b1;
        end
      end
      START: begin
        state_next   = DATA;
        bit_cnt_next = '0;
        tx_out_next  = data_reg[0];
      end
      DATA: begin
        if (bit_cnt_reg == LAST_BIT) begin
          bit_cnt_next = '0;
          if (par_en_reg) begin
            state_next  = PARITY;
            tx_out_next = parity_bit;
          end else begin
            state_next = STOP;
          end
        end else begin
          bit_cnt_next = bit_cnt_reg + CNT_W'(1);
          tx_out_next  = data_reg[bit_cnt_next];
        end
      end
      PARITY: begin
        state_next = STOP;
      end
      STOP: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
      default: begin
        state_next   = IDLE;
        bit_cnt_next = '0;
        busy_next    = 1'b0;
      end
    endcase
  end

  assign TX_OUT = tx_out_reg;
  assign Busy   = busy_reg;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: expected per-cycle line/busy
// values are queued when a word is strobed and popped as the DUT emits them.
module tb_uart_tx_serializer;

  logic       CLK;
  logic       Reset;
  logic [7:0] P_DATA;
  logic       Data_valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       TX_OUT;
  logic       Busy;

  typedef struct packed {
    logic tx;
    logic busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  uart_tx_serializer #(
    .DATA_WIDTH(8)
  ) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .P_DATA    (P_DATA),
    .Data_valid(Data_valid),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .TX_OUT    (TX_OUT),
    .Busy      (Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference frame: start, LSB-first data, optional parity, stop, one idle.
  task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt);
    exp_q.push_back(exp_t'{tx: 1'b0, busy: 1'b1});
    for (int i = 0; i < 8; i++) exp_q.push_back(exp_t'{tx: d[i], busy: 1'b1});
    if (pe) exp_q.push_back(exp_t'{tx: (^d) ^ pt, busy: 1'b1});
    exp_q.push_back(exp_t'{tx: 1'b1, busy: 1'b1});
    exp_q.push_back(exp_t'{tx: 1'b1, busy: 1'b0});
  endtask

  // Strobe one word; returns at the sampling point of cycle N+1.
  task automatic fire(input logic [7:0] d, input logic pe, input logic pt);
    @(negedge CLK);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    Data_valid = 1'b1;
    push_frame(d, pe, pt);
    @(negedge CLK);
    Data_valid = 1'b0;
  endtask

  task automatic test_reset;
    #1 Reset = 1'b0;
    #2;
    checks++;
    if ({TX_OUT, Busy} !== 2'b10) begin
      errors++;
      $display("FAIL reset_async tx/busy=%b%b want 10", TX_OUT, Busy);
    end
    repeat (2) @(negedge CLK);
    checks++;
    if ({TX_OUT, Busy} !== 2'b10) begin
      errors++;
      $display("FAIL reset_hold tx/busy=%b%b want 10", TX_OUT, Busy);
    end
    Reset = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if ({TX_OUT, Busy} !== 2'b10) begin
      errors++;
      $display("FAIL idle_after_reset tx/busy=%b%b want 10", TX_OUT, Busy);
    end
    $display("reset: line idle-high, busy low");
  endtask

  task automatic test_frames;
    logic [7:0] d_tab [6];
    logic       pe_tab[6];
    logic       pt_tab[6];
    d_tab  = '{8'hA5, 8'hA5, 8'hA5, 8'h07, 8'h00, 8'hFF};
    pe_tab = '{1'b0,  1'b1,  1'b1,  1'b1,  1'b1,  1'b1};
    pt_tab = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
    for (int c = 0; c < 8; c++) begin
      logic [7:0] d;
      logic       pe, pt;
      logic [9:0] obs;
      int         busy_cnt, k;
      exp_t       e;
      if (c < 6) begin
        d = d_tab[c]; pe = pe_tab[c]; pt = pt_tab[c];
      end else begin
        d = 8'($urandom_range(0, 255)); pe = 1'($urandom_range(0, 1)); pt = 1'($urandom_range(0, 1));
      end
      fire(d, pe, pt);
      busy_cnt = 0;
      k = 0;
      obs = '0;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({TX_OUT, Busy} !== {e.tx, e.busy}) begin
          errors++;
          $display("FAIL frame d=%h pe=%b pt=%b cyc=N+%0d tx/busy=%b%b want %b%b",
                   d, pe, pt, k + 1, TX_OUT, Busy, e.tx, e.busy);
        end
        if (Busy === 1'b1) busy_cnt++;
        if (k < 10) obs = {obs[8:0], TX_OUT};
        k++;
        if (exp_q.size() > 0) @(negedge CLK);
      end
      checks++;
      if (busy_cnt != (pe ? 11 : 10)) begin
        errors++;
        $display("FAIL busy_len d=%h pe=%b got %0d want %0d", d, pe, busy_cnt, pe ? 11 : 10);
      end
      if (c == 0) begin
        checks++;
        if (obs !== 10'b0101001011) begin
          errors++;
          $display("FAIL a5_bits got %b want 0101001011", obs);
        end
      end
      $display("frame d=%h par_en=%b par_typ=%b busy_cycles=%0d", d, pe, pt, busy_cnt);
    end
  endtask

  task automatic test_ignore_valid;
    int   k;
    exp_t e;
    fire(8'h00, 1'b0, 1'b0);
    repeat (3) exp_q.push_back(exp_t'{tx: 1'b1, busy: 1'b0});
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({TX_OUT, Busy} !== {e.tx, e.busy}) begin
        errors++;
        $display("FAIL ignore_valid cyc=N+%0d tx/busy=%b%b want %b%b", k + 1, TX_OUT, Busy, e.tx, e.busy);
      end
      k++;
      if (exp_q.size() > 0) @(negedge CLK);
      if (k == 3) begin
        P_DATA = 8'hFF; Data_valid = 1'b1; PAR_EN = 1'b1; PAR_TYP = 1'b1;
      end else if (k == 4) begin
        Data_valid = 1'b0;
      end
    end
    PAR_EN = 1'b0; PAR_TYP = 1'b0;
    $display("frame d=00 with stray strobe of ff at N+4: strobe ignored");
  endtask

  task automatic test_back_to_back;
    bit   sent2, dv_clear;
    exp_t e;
    int   k;
    fire(8'h12, 1'b0, 1'b0);
    sent2 = 1'b0;
    dv_clear = 1'b0;
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({TX_OUT, Busy} !== {e.tx, e.busy}) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d tx/busy=%b%b want %b%b", k, TX_OUT, Busy, e.tx, e.busy);
      end
      if (dv_clear) begin
        Data_valid = 1'b0;
        dv_clear = 1'b0;
      end
      if (!sent2 && exp_q.size() == 0) begin
        P_DATA = 8'h34; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_valid = 1'b1;
        push_frame(8'h34, 1'b0, 1'b0);
        sent2 = 1'b1;
        dv_clear = 1'b1;
      end
      k++;
      if (exp_q.size() > 0) @(negedge CLK);
    end
    $display("frames d=12 then d=34 back to back, one idle cycle between");
  endtask

  task automatic test_mid_reset;
    exp_t e;
    fire(8'hC3, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      checks++;
      if ({TX_OUT, Busy} !== {e.tx, e.busy}) begin
        errors++;
        $display("FAIL pre_abort cyc=N+%0d tx/busy=%b%b want %b%b", k + 1, TX_OUT, Busy, e.tx, e.busy);
      end
      @(negedge CLK);
    end
    exp_q.delete();
    Reset = 1'b0;
    #1;
    checks++;
    if ({TX_OUT, Busy} !== 2'b10) begin
      errors++;
      $display("FAIL abort_async tx/busy=%b%b want 10", TX_OUT, Busy);
    end
    @(negedge CLK);
    checks++;
    if ({TX_OUT, Busy} !== 2'b10) begin
      errors++;
      $display("FAIL abort_hold tx/busy=%b%b want 10", TX_OUT, Busy);
    end
    Reset = 1'b1;
    P_DATA = 8'h3C; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_valid = 1'b1;
    push_frame(8'h3C, 1'b0, 1'b0);
    @(negedge CLK);
    Data_valid = 1'b0;
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      checks++;
      if ({TX_OUT, Busy} !== {e.tx, e.busy}) begin
        errors++;
        $display("FAIL post_reset d=3c cyc=N+%0d tx/busy=%b%b want %b%b", k + 1, TX_OUT, Busy, e.tx, e.busy);
      end
      if (exp_q.size() > 0) @(negedge CLK);
    end
    $display("frame d=c3 aborted by reset at N+5, then d=3c on first edge after release");
  endtask

  initial begin
    Reset      = 1'b1;
    P_DATA     = '0;
    Data_valid = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    test_reset();
    test_frames();
    test_ignore_valid();
    test_back_to_back();
    test_mid_reset();
    repeat (2) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, width of the parallel data word.
REQ-002 CLK  input  1  bit-rate clock; one serial bit period per CLK cycle.
REQ-003 Reset  input  1  asynchronous, active-low reset.
REQ-004 P_DATA  input  DATA_WIDTH  parallel word from the Tx control stage.
REQ-005 Data_valid  input  1  single-cycle strobe qualifying P_DATA.
REQ-006 PAR_EN  input  1  1 = insert a parity bit after the data bits.
REQ-007 PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 TX_OUT  output  1  serial line, registered, idle high.
REQ-009 Busy  output  1  registered; high while a frame is in progress.

Function
REQ-010 States SHALL be IDLE, START, DATA, PARITY and STOP.
REQ-011 In IDLE, TX_OUT SHALL be 1 and Busy SHALL be 0.
REQ-012 Acceptance:
  - A word SHALL be accepted only when Data_valid=1 in a cycle where the state is IDLE.
  - On that edge, P_DATA, PAR_EN and PAR_TYP SHALL be latched into internal registers.
REQ-013 Data_valid SHALL be ignored in every state other than IDLE; no queuing and no corruption of the frame in flight.
REQ-014 Frame timing, with acceptance in cycle N:
  - cycle N+1: START, TX_OUT=0, Busy=1.
  - cycles N+2 .. N+1+DATA_WIDTH: DATA, latched bits sent LSB first, one bit per cycle.
REQ-015 Bit counter:
  - counts 0 .. DATA_WIDTH-1 in DATA;
  - is cleared on leaving DATA;
  - width is ceil(log2(DATA_WIDTH)).
REQ-016 If the latched PAR_EN=1, the next cycle after the last data bit SHALL be PARITY:
  - TX_OUT = XOR of the latched data when latched PAR_TYP=0 (even);
  - TX_OUT = its inverse when latched PAR_TYP=1 (odd).
REQ-017 After the last data bit (PAR_EN=0) or after PARITY (PAR_EN=1), the next cycle SHALL be STOP with TX_OUT=1.
REQ-018 From STOP the FSM SHALL return to IDLE on the next edge; Busy SHALL be 0 in the cycle after STOP.
REQ-019 Busy duration:
  - Busy SHALL be high for exactly DATA_WIDTH+2 cycles (parity off) or DATA_WIDTH+3 cycles (parity on);
  - Busy SHALL rise exactly one cycle after the accepting edge (upstream wait-one-cycle contract).
REQ-020 Back-to-back: a Data_valid asserted in the first IDLE cycle after STOP SHALL be accepted; minimum inter-frame gap is one idle-high cycle.
REQ-021 Changes on PAR_EN/PAR_TYP/P_DATA during a frame SHALL NOT affect that frame.
REQ-022 Illegal state encodings SHALL recover to IDLE on the next edge with TX_OUT=1 and Busy=0.

Reset
REQ-023 Reset=0 SHALL asynchronously force:
  - state=IDLE, TX_OUT=1, Busy=0;
  - bit counter=0, data/parity registers=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately; no partial resumption after release.
REQ-025 The first edge after reset release SHALL accept a word if Data_valid=1.

Structure
REQ-026 Shared package contents:
  - state encoding constants (IDLE, START, DATA, PARITY, STOP);
  - default DATA_WIDTH;
  - parity-type constants EVEN=0, ODD=1.
REQ-027 Parity generation SHALL be a separate sub-module tx_parity_calc, taking the latched word and type and producing the parity bit.
REQ-028 Datapath and FSM SHALL be fully synchronous to CLK, with no combinational path from inputs to TX_OUT or Busy.

Verification
REQ-029 0xA5, PAR_EN=0 -> TX_OUT 0,1,0,1,0,0,1,0,1,1 over cycles N+1..N+10; Busy high 10 cycles.
REQ-030 0xA5, PAR_EN=1, PAR_TYP=0 -> parity bit 0 at N+10, stop 1 at N+11; same word with PAR_TYP=1 -> parity bit 1.
REQ-031 0x07, PAR_EN=1, PAR_TYP=0 -> parity bit 1; Busy high 11 cycles, then low.
REQ-032 Data_valid pulsed with 0xFF at N+4 during a 0x00 frame -> frame stays all-zero data, 0xFF is never sent.
REQ-033 Reset pulsed low at N+5 -> TX_OUT=1 and Busy=0 immediately; next accepted 0x3C is sent correctly.
REQ-034 Two words 0x12, 0x34, second strobed in the first IDLE cycle after the first STOP -> both frames are correct, with one idle-high cycle between them.
